// File: rtl/fs_arbiter_if.sv
// fs_arbiter requester-side bundle.
// Per-requester burst/strobe lanes in, grant and fsQ broadcast out.
interface fs_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      rden;
  logic [NREQ-1:0]      wren;
  logic [32*NREQ-1:0]   filename;
  logic [32*NREQ-1:0]   address;
  logic [32*NREQ-1:0]   data;
  logic [NREQ-1:0]      gnt;
  logic [31:0]          q;
  logic                 timeout_err;

  modport master (
    output req, rden, wren,
    output filename, address, data,
    input  gnt, q, timeout_err
  );

  modport slave (
    input  req, rden, wren,
    input  filename, address, data,
    output gnt, q, timeout_err
  );
endinterface

// File: rtl/fs_arbiter.sv
// Round-robin owner of the single filesystem port.
// Burst-level grants, zero-latency forwarding, hold-time watchdog.
module fs_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst,
  fs_arbiter_if.slave bus,
  output logic        o_fsRden,
  output logic        o_fsWren,
  output logic [31:0] o_fsFilename,
  output logic [31:0] o_fsAddress,
  output logic [31:0] o_fsData,
  input  logic [31:0] i_fsQ
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit C_WDOG = (TIMEOUT > 0);
  localparam logic [CW-1:0] C_TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] C_TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_revoked;
  logic [LW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout_err;

  logic [NREQ-1:0] w_elig;
  logic [LW-1:0]   w_win;
  logic            w_found;
  logic            w_own_req;
  logic            w_expire;

  assign w_elig    = bus.req & ~r_revoked;
  assign w_own_req = bus.req[r_last];

  assign bus.gnt         = r_gnt;
  assign bus.q           = i_fsQ;
  assign bus.timeout_err = r_timeout_err;

  // round-robin search upward from the previous winner
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(r_last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && w_elig[j]) begin
        w_found = 1'b1;
        w_win   = LW'(j);
      end
    end
  end

  // next-state: release wins over an expiry on the same edge
  always_comb begin
    w_next   = r_state;
    w_expire = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_next = GRANT;
      end
      GRANT: begin
        if (!w_own_req) begin
          w_next = DRAIN;
        end else if (C_WDOG && r_cnt == C_TLAST) begin
          w_next   = DRAIN;
          w_expire = 1'b1;
        end
      end
      DRAIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // grant, last winner and hold counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt  <= '0;
      r_last <= LW'(NREQ - 1);
      r_cnt  <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_gnt  <= NREQ'(1) << w_win;
        r_last <= w_win;
        r_cnt  <= '0;
      end else if (r_state == GRANT) begin
        if (w_next != GRANT) r_gnt <= '0;
        if (r_cnt != C_TMAX) r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // revoke on expiry, forgive once the requester lets go
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_revoked     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_expire;
      r_revoked     <= (r_revoked & bus.req)
                     | (w_expire ? (NREQ'(1) << r_last)
                                 : '0);
    end
  end

  // fs port follows the owner only while in GRANT
  always_comb begin
    o_fsRden     = 1'b0;
    o_fsWren     = 1'b0;
    o_fsFilename = '0;
    o_fsAddress  = '0;
    o_fsData     = '0;
    if (r_state == GRANT) begin
      o_fsRden     = bus.rden[r_last];
      o_fsWren     = bus.wren[r_last];
      o_fsFilename = bus.filename[32*r_last +: 32];
      o_fsAddress  = bus.address[32*r_last +: 32];
      o_fsData     = bus.data[32*r_last +: 32];
    end
  end
endmodule

// File: tb/tb_fs_arbiter.sv
// Scoreboard bench for fs_arbiter.
// Burst-level reference model feeds a queue; a negedge monitor checks.
module tb_fs_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fsRden, fsWren;
  logic [31:0] fsFilename, fsAddress, fsData, fsQ;

  fs_arbiter_if #(.NREQ(N)) bus ();

  fs_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_fsRden    (fsRden),
    .o_fsWren    (fsWren),
    .o_fsFilename(fsFilename),
    .o_fsAddress (fsAddress),
    .o_fsData    (fsData),
    .i_fsQ       (fsQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic         rd;
    logic         wr;
    logic [31:0]  fn;
    logic [31:0]  ad;
    logic [31:0]  da;
    logic [31:0]  q;
    logic         terr;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // reference: who owns the port, how long, who is banned
  int         m_owner = -1;
  int         m_last  = N - 1;
  int         m_hold  = 0;
  int         m_gap   = 0;
  bit [N-1:0] m_rev   = '0;
  bit         m_terr  = 1'b0;

  int cnt_g0, cnt_g1, cnt_terr;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int c;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_hold  = 0;
      m_gap   = 0;
      m_rev   = '0;
      m_terr  = 1'b0;
      return;
    end
    m_terr = 1'b0;
    if (m_owner >= 0) begin
      if (!bus.req[m_owner]) begin
        m_owner = -1;
        m_gap   = 1;
      end else if (m_hold + 1 == TO) begin
        m_rev[m_owner] = 1'b1;
        m_terr  = 1'b1;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (bus.req[c] && !m_rev[c]) begin
          m_owner = c;
          m_last  = c;
          m_hold  = 0;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (!bus.req[i]) m_rev[i] = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.gnt  = '0;
    e.rd   = 1'b0;
    e.wr   = 1'b0;
    e.fn   = '0;
    e.ad   = '0;
    e.da   = '0;
    e.q    = fsQ;
    e.terr = m_terr;
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.rd = bus.rden[m_owner];
      e.wr = bus.wren[m_owner];
      e.fn = bus.filename[32*m_owner +: 32];
      e.ad = bus.address[32*m_owner +: 32];
      e.da = bus.data[32*m_owner +: 32];
    end
    sbq.push_back(e);
  endtask

  task automatic apply(input logic [N-1:0] r,
                       input logic [N-1:0] rd,
                       input logic [N-1:0] wr,
                       input logic rs);
    rst          = rs;
    bus.req      = r;
    bus.rden     = rd;
    bus.wren     = wr;
    bus.filename = {$urandom(), $urandom(), $urandom()};
    bus.address  = {$urandom(), $urandom(), $urandom()};
    bus.data     = {$urandom(), $urandom(), $urandom()};
    fsQ          = $urandom();
  endtask

  task automatic begin_cyc(input logic [N-1:0] r,
                           input logic [N-1:0] rd,
                           input logic [N-1:0] wr,
                           input logic rs);
    @(posedge clk);
    model_step();
    #1;
    apply(r, rd, wr, rs);
  endtask

  task automatic end_cyc();
    push_exp();
    #1;
    if (bus.gnt[0])     cnt_g0++;
    if (bus.gnt[1])     cnt_g1++;
    if (bus.timeout_err) cnt_terr++;
  endtask

  task automatic cyc(input logic [N-1:0] r,
                     input logic rs);
    begin_cyc(r, N'($urandom()), N'($urandom()), rs);
    end_cyc();
  endtask

  task automatic clr_cnt();
    cnt_g0   = 0;
    cnt_g1   = 0;
    cnt_terr = 0;
  endtask

  // monitor: one expected entry per cycle
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("gnt",      32'(bus.gnt),         32'(e.gnt));
      chk("fsRden",   32'(fsRden),          32'(e.rd));
      chk("fsWren",   32'(fsWren),          32'(e.wr));
      chk("fsFilename", fsFilename,          e.fn);
      chk("fsAddress", fsAddress,            e.ad);
      chk("fsData",   fsData,               e.da);
      chk("q",        bus.q,                e.q);
      chk("timeout_err", 32'(bus.timeout_err), 32'(e.terr));
    end
  end

  initial begin
    logic [N-1:0] r;
    logic         rs;
    clr_cnt();
    apply('0, '0, '0, 1'b1);

    cyc(3'b000, 1'b1);
    cyc(3'b011, 1'b0);
    begin_cyc(3'b011, 3'b001, 3'b010, 1'b0);
    fsQ = 32'hcafef00d;
    end_cyc();
    chk("first_gnt", 32'(bus.gnt), 32'd1);
    chk("q_pass", bus.q, 32'hcafef00d);
    chk("own_rden", 32'(fsRden), 32'd1);
    chk("nonown_wren", 32'(fsWren), 32'd0);

    begin_cyc(3'b010, 3'b111, 3'b111, 1'b0);
    end_cyc();
    chk("fwd_on_fall", 32'(fsWren), 32'd1);
    begin_cyc(3'b011, 3'b111, 3'b111, 1'b0);
    end_cyc();
    chk("gap1_gnt", 32'(bus.gnt), 32'd0);
    chk("gap1_fn", fsFilename, 32'd0);
    begin_cyc(3'b011, 3'b111, 3'b111, 1'b0);
    end_cyc();
    chk("gap2_gnt", 32'(bus.gnt), 32'd0);
    chk("gap2_wr", 32'(fsWren), 32'd0);

    begin_cyc(3'b011, 3'b000, 3'b011, 1'b0);
    bus.filename[63:32] = 32'h2f646576;
    bus.address[63:32]  = 32'h00001234;
    bus.data[63:32]     = 32'hdeadbeef;
    end_cyc();
    chk("gnt_1", 32'(bus.gnt), 32'd2);
    chk("fn_1", fsFilename, 32'h2f646576);
    chk("ad_1", fsAddress, 32'h00001234);
    chk("da_1", fsData, 32'hdeadbeef);

    repeat (4) cyc(3'b001, 1'b0);
    chk("regrant_0", 32'(bus.gnt), 32'd1);

    begin_cyc(3'b011, 3'b000, 3'b001, 1'b1);
    end_cyc();
    begin_cyc(3'b011, 3'b000, 3'b001, 1'b0);
    end_cyc();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_wren", 32'(fsWren), 32'd0);
    chk("rst_fn", fsFilename, 32'd0);
    cyc(3'b011, 1'b0);
    chk("rst_first", 32'(bus.gnt), 32'd1);

    cyc(3'b000, 1'b1);
    cyc(3'b000, 1'b0);
    cyc(3'b011, 1'b0);
    clr_cnt();
    repeat (30) cyc(3'b011, 1'b0);
    chk("wd_g0_len", cnt_g0, 32'd8);
    chk("wd_g1_len", cnt_g1, 32'd8);
    chk("wd_pulses", cnt_terr, 32'd2);
    chk("wd_banned", 32'(bus.gnt), 32'd0);
    cyc(3'b010, 1'b0);
    cyc(3'b011, 1'b0);
    cyc(3'b011, 1'b0);
    chk("unban_0", 32'(bus.gnt), 32'd1);

    cyc(3'b000, 1'b1);
    cyc(3'b000, 1'b0);
    cyc(3'b000, 1'b0);
    clr_cnt();
    repeat (8) cyc(3'b001, 1'b0);
    repeat (4) cyc(3'b000, 1'b0);
    chk("edge_len", cnt_g0, 32'd8);
    chk("edge_noerr", cnt_terr, 32'd0);
    cyc(3'b001, 1'b0);
    cyc(3'b001, 1'b0);
    chk("edge_norevoke", 32'(bus.gnt), 32'd1);

    r = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
      rs = ($urandom_range(0, 399) == 0);
      cyc(r, rs);
    end

    for (int i = 0; i < 4 && sbq.size() > 0; i++)
      @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/fs_arbiter.md
# fs_arbiter

Round-robin arbiter that shares the single filesystem port (fsRden/fsWren/fsFilename/fsAddress/fsData/fsQ) between NREQ requesters, e.g. the port-a/port-b pagers and the CPU file syscall unit. A requester holds `req` for an entire burst (filename open sequence plus data transfers) and owns the port exclusively while granted. Sits between the requesters and the filesystem device; it adds no latency to granted traffic and enforces a hold-time watchdog.

## Interface
- NREQ, 2: number of requesters (2..8).
- TIMEOUT, 65536: maximum cycles a grant may be held; 0 disables the watchdog.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester burst request, level; held for the whole burst.
- rden  in  NREQ  per-requester fs read strobe.
- wren  in  NREQ  per-requester fs write strobe.
- filename  in  32*NREQ  per-requester filename word; requester i at [32*i+31:32*i].
- address  in  32*NREQ  per-requester fs address, same packing.
- data  in  32*NREQ  per-requester fs write data, same packing.
- gnt  out  NREQ  one-hot grant, registered.
- q  out  32  fsQ broadcast to all requesters, combinational pass-through.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- fsRden, fsWren  out  1  to filesystem.
- fsFilename, fsAddress, fsData  out  32  to filesystem.
- fsQ  in  32  from filesystem.

## Operation
- States: IDLE, GRANT, DRAIN; 2-bit state register.
- IDLE: if any eligible `req` is high, choose the winner by searching upward from `last+1` modulo NREQ; set `gnt[winner]`, `last <= winner`, hold counter to 0, go to GRANT. Otherwise stay in IDLE.
- Eligible: `req[i]` is high and `revoked[i]` is 0.
- GRANT:
  - fs outputs are driven combinationally from the owner's rden/wren/filename/address/data.
  - The hold counter increments each cycle, saturating at TIMEOUT.
  - Owner `req` low: clear `gnt`, go to DRAIN.
  - Counter reaches TIMEOUT-1 with `req` still high: clear `gnt`, set `revoked[owner]`, pulse `timeout_err`, go to DRAIN.
- DRAIN: one cycle with all fs outputs at 0, which returns fsFilename to 0 so the next owner's open sequence starts clean; then go to IDLE.
- In IDLE and DRAIN, fsRden, fsWren, fsFilename, fsAddress and fsData are forced to 0.
- `revoked[i]` clears on any cycle in which `req[i]` is low.
- Strobes from non-owners are ignored. They must not reach the fs port and produce no error.
- Hold counter width is clog2(TIMEOUT+1); with TIMEOUT=0 it never triggers.
- Reset values: state IDLE, `gnt` 0, `last` NREQ-1 (requester 0 wins first), counter 0, `revoked` 0, `timeout_err` 0. All fs outputs read 0 because the state is IDLE.

## Timing
- `req[i]` high at edge n in IDLE: `gnt[i]` high after edge n. The requester drives strobes from cycle n+1; the fs port sees them the same cycle.
- fsQ to `q`: 0 added cycles. Requester-visible fs latency equals the device latency.
- Owner `req` low sampled at edge k: `gnt` low after k (DRAIN), IDLE after k+1, next `gnt` after k+2. The minimum gap between owners is 2 cycles of zero fs outputs.
- Watchdog: a grant lasts exactly TIMEOUT cycles. `timeout_err` is high in the first DRAIN cycle only.
- Owner drops `req` on the same edge the counter expires: treat as a normal release, with no `timeout_err` and no revoke.
- All `req` high continuously: grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 bursts.
- `rst` during GRANT: `gnt` and fs outputs are 0 after that edge. Arbitration restarts from requester 0.
- Owner strobes in the cycle `req` falls are still forwarded, because the mux follows the registered state.

## Test plan
- Reset then `req`=2'b11 held: gnt=01 after edge 1. Drop req[0] for one cycle: gnt 00, 00, then 10. The fs outputs are 0 in both gap cycles.
- Owner 1 drives filename 32'h2f646576, address 32'h1234, wren=1 with data 32'hdeadbeef: the fs port shows the same values in the same cycle. Requester 0's simultaneous wren=1 is not forwarded.
- fsQ=32'hcafef00d during requester 0's read: `q`=32'hcafef00d the same cycle.
- TIMEOUT=8, req[0] held indefinitely: gnt[0] high for exactly 8 cycles, then `timeout_err` pulses once. req[1] is granted 2 cycles later. req[0] is not re-granted until it goes low for one cycle.
- Owner drops `req` on the expiry edge (TIMEOUT=8, release at cycle 8): `timeout_err` stays 0 and `revoked` stays 0.
- `rst` asserted mid-burst with fsWren=1: after the edge gnt=0, fsWren=0, fsFilename=0. With both req high, the next grant goes to requester 0.
